// File: rtl/inference_perf_monitor_pkg.sv
// Shared types and defaults for the inference run monitor.
// The watchdog is only built when PERF_MON_WATCHDOG_EN is defined.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam int unsigned CntWidth         = 64;
  localparam int unsigned DefaultExitMagic = 99999;

endpackage

// File: rtl/inference_perf_monitor_if.sv
// Snoop bus from the scalar core plus the monitor's status/statistics outputs.
// master = core/debug side, slave = monitor.
interface perf_mon_if #(
  parameter int unsigned DWidth   = 32,
  parameter int unsigned LatWidth = 32
);
  import perf_mon_pkg::*;

  logic                rf_we_i;
  logic [4:0]          rf_waddr_i;
  logic [DWidth-1:0]   rf_wdata_i;
  logic                retire_i;

  state_e              state_o;
  logic [DWidth-1:0]   img_idx_o;
  logic [DWidth-1:0]   correct_o;
  logic [CntWidth-1:0] cycle_o;
  logic [CntWidth-1:0] instret_o;
  logic [LatWidth-1:0] lat_last_o;
  logic [LatWidth-1:0] lat_min_o;
  logic [LatWidth-1:0] lat_max_o;
  logic                img_done_o;
  logic                done_o;
  logic                timeout_o;

  modport master (
    output rf_we_i, rf_waddr_i, rf_wdata_i, retire_i,
    input  state_o, img_idx_o, correct_o, cycle_o, instret_o,
           lat_last_o, lat_min_o, lat_max_o, img_done_o, done_o, timeout_o
  );

  modport slave (
    input  rf_we_i, rf_waddr_i, rf_wdata_i, retire_i,
    output state_o, img_idx_o, correct_o, cycle_o, instret_o,
           lat_last_o, lat_min_o, lat_max_o, img_done_o, done_o, timeout_o
  );

endinterface

// File: rtl/inference_perf_monitor_lat_tracker.sv
// Per-image latency tracker: saturating running count plus last/min/max of completed images.
// The completed latency includes the boundary cycle itself, hence lat_cur+1.
module perf_lat_tracker #(
  parameter int unsigned LatWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear,
  input  logic                tick,
  input  logic                capture,
  input  logic                skip_stats,
  output logic [LatWidth-1:0] lat_last,
  output logic [LatWidth-1:0] lat_min,
  output logic [LatWidth-1:0] lat_max
);

  localparam logic [LatWidth-1:0] LatAllOnes = '1;
  localparam logic [LatWidth-1:0] LatOne     = LatWidth'(1);

  logic [LatWidth-1:0] lat_cur;
  logic [LatWidth-1:0] lat_done;

  function automatic logic [LatWidth-1:0] sat_inc(input logic [LatWidth-1:0] v);
    return (v == LatAllOnes) ? v : v + LatOne;
  endfunction

  assign lat_done = sat_inc(lat_cur);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_cur  <= '0;
      lat_last <= '0;
      lat_min  <= LatAllOnes;
      lat_max  <= '0;
    end else begin
      if (clear || capture) begin
        lat_cur <= '0;
      end else if (tick) begin
        lat_cur <= lat_done;
      end
      // A restart to image 0 ends the running count but is not a real image.
      if (capture && !skip_stats) begin
        lat_last <= lat_done;
        if (lat_done < lat_min) lat_min <= lat_done;
        if (lat_done > lat_max) lat_max <= lat_done;
      end
    end
  end

endmodule

// File: rtl/inference_perf_monitor.sv
// Run monitor for the MLP inference program: snoops GPR writes, counts cycles/retires in RUN,
// and records per-image latency. Optional watchdog built when PERF_MON_WATCHDOG_EN is defined.
module inference_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int unsigned DWidth    = 32,
  parameter int unsigned LatWidth  = 32,
  parameter int unsigned NumOfTest = 1000,
  parameter int unsigned ProgReg   = 26,
  parameter int unsigned CorrReg   = 27,
  parameter int unsigned ExitReg   = 25,
  parameter int unsigned ExitMagic = DefaultExitMagic
`ifdef PERF_MON_WATCHDOG_EN
  ,
  parameter int unsigned TimeoutCyc = 2**24
`endif
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  perf_mon_if.slave mon
);

  state_e              state_q, state_d;
  logic [DWidth-1:0]   img_idx_q, correct_q;
  logic [CntWidth-1:0] cycle_q, instret_q;
  logic                img_done_q;

  logic wr_vld, prog_wr, corr_wr, exit_wr;
  logic in_run, run_start, snoop_en, boundary, finish, wd_expire, skip_stats;

  assign wr_vld    = mon.rf_we_i && (mon.rf_waddr_i != 5'd0);
  assign prog_wr   = wr_vld && (mon.rf_waddr_i == 5'(ProgReg));
  assign corr_wr   = wr_vld && (mon.rf_waddr_i == 5'(CorrReg));
  assign exit_wr   = wr_vld && (mon.rf_waddr_i == 5'(ExitReg));

  assign in_run    = (state_q == RUN);
  assign run_start = (state_q == IDLE) && mon.retire_i;
  assign snoop_en  = (state_q == IDLE) || (state_q == RUN);
  assign boundary  = in_run && prog_wr && (mon.rf_wdata_i != img_idx_q);
  assign finish    = in_run &&
                     ((exit_wr && (mon.rf_wdata_i == DWidth'(ExitMagic))) ||
                      (prog_wr && (mon.rf_wdata_i == DWidth'(NumOfTest))));
  assign skip_stats = (mon.rf_wdata_i == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Normal completion wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mon.retire_i) state_d = RUN;
      RUN: begin
        if (finish)         state_d = DONE;
        else if (wd_expire) state_d = TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

`ifdef PERF_MON_WATCHDOG_EN
  localparam int unsigned        WdWidth = (TimeoutCyc > 2) ? $clog2(TimeoutCyc) : 1;
  localparam logic [WdWidth-1:0] WdLast  = WdWidth'(TimeoutCyc - 1);

  logic [WdWidth-1:0] wd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (run_start || boundary) begin
      wd_q <= '0;
    end else if (in_run) begin
      wd_q <= wd_q + WdWidth'(1);
    end
  end

  assign wd_expire     = in_run && !boundary && (wd_q == WdLast);
  assign mon.timeout_o = (state_q == TIMEOUT);
`else
  assign wd_expire     = 1'b0;
  assign mon.timeout_o = 1'b0;
`endif

  // The retire that starts the run is already counted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (run_start || in_run) begin
      cycle_q <= cycle_q + CntWidth'(1);
      if (mon.retire_i) instret_q <= instret_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      img_idx_q  <= '0;
      correct_q  <= '0;
      img_done_q <= 1'b0;
    end else begin
      img_done_q <= boundary;
      if (snoop_en && prog_wr) img_idx_q <= mon.rf_wdata_i;
      if (snoop_en && corr_wr) correct_q <= mon.rf_wdata_i;
    end
  end

  perf_lat_tracker #(
    .LatWidth (LatWidth)
  ) u_lat (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear      (run_start),
    .tick       (in_run),
    .capture    (boundary),
    .skip_stats (skip_stats),
    .lat_last   (mon.lat_last_o),
    .lat_min    (mon.lat_min_o),
    .lat_max    (mon.lat_max_o)
  );

  assign mon.state_o    = state_q;
  assign mon.img_idx_o  = img_idx_q;
  assign mon.correct_o  = correct_q;
  assign mon.cycle_o    = cycle_q;
  assign mon.instret_o  = instret_q;
  assign mon.img_done_o = img_done_q;
  assign mon.done_o     = (state_q == DONE);

endmodule
